// File: rtl/lec_codebook_engine.sv
// Table-driven low-entropy codebook engine: accumulates a symbol prefix, matches it
// against a loadable table and emits the codeword. Optional miss beat: LEC_MISS_FLAG_EN.
module lec_codebook_engine #(
    parameter int NUM_CODES   = 16,
    parameter int SYM_WIDTH   = 4,
    parameter int PREFIX_MAX  = 16,
    parameter int TABLE_DEPTH = 64,
    parameter int CW_WIDTH    = 21,
    localparam int CODE_W     = $clog2(NUM_CODES),
    localparam int AP_W       = PREFIX_MAX * SYM_WIDTH,
    localparam int ADDR_W     = $clog2(TABLE_DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    input  logic [SYM_WIDTH-1:0] s_sym_i,
    input  logic                s_flush_i,
    input  logic [CODE_W-1:0]   s_code_i,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic [CW_WIDTH-1:0] m_data_o,
    output logic [5:0]          m_len_o,
    output logic [CODE_W-1:0]   m_code_o,
`ifdef LEC_MISS_FLAG_EN
    output logic                m_err_o,
`endif
    input  logic                cfg_we_i,
    input  logic [ADDR_W-1:0]   cfg_addr_i,
    input  logic [CODE_W-1:0]   cfg_code_i,
    input  logic [5:0]          cfg_plen_i,
    input  logic [AP_W-1:0]     cfg_prefix_i,
    input  logic [5:0]          cfg_cwlen_i,
    input  logic [CW_WIDTH-1:0] cfg_cw_i
);
    typedef enum logic [1:0] {IDLE, ACCUM, LOOKUP, EMIT} state_t;

    state_t              state_q, state_d;
    logic [AP_W-1:0]     ap_data_q, ap_data_d;
    logic [5:0]          ap_cnt_q, ap_cnt_d;
    logic [CODE_W-1:0]   cur_code_q, cur_code_d;
    logic                marker_q, marker_d;
    logic [CW_WIDTH-1:0] m_data_q, m_data_d;
    logic [5:0]          m_len_q, m_len_d;
    logic [CODE_W-1:0]   m_code_q, m_code_d;
`ifdef LEC_MISS_FLAG_EN
    logic                m_err_q, m_err_d;
`endif

    logic [CODE_W-1:0]   tbl_code_q   [TABLE_DEPTH], tbl_code_d   [TABLE_DEPTH];
    logic [5:0]          tbl_plen_q   [TABLE_DEPTH], tbl_plen_d   [TABLE_DEPTH];
    logic [AP_W-1:0]     tbl_prefix_q [TABLE_DEPTH], tbl_prefix_d [TABLE_DEPTH];
    logic [5:0]          tbl_cwlen_q  [TABLE_DEPTH], tbl_cwlen_d  [TABLE_DEPTH];
    logic [CW_WIDTH-1:0] tbl_cw_q     [TABLE_DEPTH], tbl_cw_d     [TABLE_DEPTH];

    logic [AP_W-1:0]      mask;
    logic                 hit;
    logic [ADDR_W-1:0]    hit_idx;
    logic [SYM_WIDTH-1:0] sym_eff;

    // Only the low ap_cnt symbols of a table prefix take part in the compare;
    // scanning downwards makes the lowest hitting address the winner.
    always_comb begin
        mask    = '0;
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < PREFIX_MAX; i++)
            if (6'(i) < ap_cnt_q) mask[i*SYM_WIDTH +: SYM_WIDTH] = '1;
        for (int a = TABLE_DEPTH - 1; a >= 0; a--)
            if (tbl_plen_q[a] != 6'd0 && tbl_plen_q[a] == ap_cnt_q &&
                tbl_code_q[a] == cur_code_q &&
                (tbl_prefix_q[a] & mask) == ap_data_q) begin
                hit     = 1'b1;
                hit_idx = ADDR_W'(a);
            end
    end

    always_comb begin
        sym_eff    = (s_flush_i || s_sym_i == '1) ? '1 : s_sym_i;
        state_d    = state_q;
        ap_data_d  = ap_data_q;
        ap_cnt_d   = ap_cnt_q;
        cur_code_d = cur_code_q;
        marker_d   = marker_q;
        m_data_d   = m_data_q;
        m_len_d    = m_len_q;
        m_code_d   = m_code_q;
`ifdef LEC_MISS_FLAG_EN
        m_err_d    = m_err_q;
`endif
        case (state_q)
            IDLE: state_d = ACCUM;
            ACCUM: if (s_valid_i) begin
                ap_data_d = {ap_data_q[AP_W-SYM_WIDTH-1:0], sym_eff};
                ap_cnt_d  = 6'(ap_cnt_q + 6'd1);
                marker_d  = (sym_eff == '1);
                if (ap_cnt_q == 6'd0) cur_code_d = s_code_i;
                state_d   = LOOKUP;
            end
            LOOKUP: begin
                state_d = ACCUM;
                if (hit) begin
                    m_data_d = tbl_cw_q[hit_idx];
                    m_len_d  = tbl_cwlen_q[hit_idx];
                    m_code_d = cur_code_q;
`ifdef LEC_MISS_FLAG_EN
                    m_err_d  = 1'b0;
`endif
                    state_d  = EMIT;
                end else if (marker_q || ap_cnt_q == 6'(PREFIX_MAX)) begin
                    ap_data_d = '0;
                    ap_cnt_d  = '0;
`ifdef LEC_MISS_FLAG_EN
                    m_data_d  = '0;
                    m_len_d   = '0;
                    m_code_d  = cur_code_q;
                    m_err_d   = 1'b1;
                    state_d   = EMIT;
`endif
                end
            end
            EMIT: if (m_ready_i) begin
                ap_data_d = '0;
                ap_cnt_d  = '0;
                state_d   = ACCUM;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tbl_code_d   = tbl_code_q;
        tbl_plen_d   = tbl_plen_q;
        tbl_prefix_d = tbl_prefix_q;
        tbl_cwlen_d  = tbl_cwlen_q;
        tbl_cw_d     = tbl_cw_q;
        if (cfg_we_i) begin
            tbl_code_d[cfg_addr_i]   = cfg_code_i;
            tbl_plen_d[cfg_addr_i]   = cfg_plen_i;
            tbl_prefix_d[cfg_addr_i] = cfg_prefix_i;
            tbl_cwlen_d[cfg_addr_i]  = cfg_cwlen_i;
            tbl_cw_d[cfg_addr_i]     = cfg_cw_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ap_data_q  <= '0;
            ap_cnt_q   <= '0;
            cur_code_q <= '0;
            marker_q   <= 1'b0;
            m_data_q   <= '0;
            m_len_q    <= '0;
            m_code_q   <= '0;
`ifdef LEC_MISS_FLAG_EN
            m_err_q    <= 1'b0;
`endif
            for (int a = 0; a < TABLE_DEPTH; a++) begin
                tbl_code_q[a]   <= '0;
                tbl_plen_q[a]   <= '0;
                tbl_prefix_q[a] <= '0;
                tbl_cwlen_q[a]  <= '0;
                tbl_cw_q[a]     <= '0;
            end
        end else begin
            state_q      <= state_d;
            ap_data_q    <= ap_data_d;
            ap_cnt_q     <= ap_cnt_d;
            cur_code_q   <= cur_code_d;
            marker_q     <= marker_d;
            m_data_q     <= m_data_d;
            m_len_q      <= m_len_d;
            m_code_q     <= m_code_d;
`ifdef LEC_MISS_FLAG_EN
            m_err_q      <= m_err_d;
`endif
            tbl_code_q   <= tbl_code_d;
            tbl_plen_q   <= tbl_plen_d;
            tbl_prefix_q <= tbl_prefix_d;
            tbl_cwlen_q  <= tbl_cwlen_d;
            tbl_cw_q     <= tbl_cw_d;
        end
    end

    assign s_ready_o = (state_q == ACCUM);
    assign m_valid_o = (state_q == EMIT);
    assign m_data_o  = m_data_q;
    assign m_len_o   = m_len_q;
    assign m_code_o  = m_code_q;
`ifdef LEC_MISS_FLAG_EN
    assign m_err_o   = m_err_q;
`endif
endmodule

// File: tb/tb_lec_codebook_engine.sv
// Directed bench for lec_codebook_engine; builds with or without LEC_MISS_FLAG_EN.
module tb_lec_codebook_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready, s_flush;
    logic [3:0]  s_sym, s_code;
    logic        m_valid, m_ready, m_err;
    logic [20:0] m_data;
    logic [5:0]  m_len;
    logic [3:0]  m_code;
    logic        cfg_we;
    logic [5:0]  cfg_addr, cfg_plen, cfg_cwlen;
    logic [3:0]  cfg_code;
    logic [63:0] cfg_prefix;
    logic [20:0] cfg_cw;
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    lec_codebook_engine dut (
        .clk_i(clk), .rst_i(rst),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_sym_i(s_sym),
        .s_flush_i(s_flush), .s_code_i(s_code),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
        .m_len_o(m_len), .m_code_o(m_code),
`ifdef LEC_MISS_FLAG_EN
        .m_err_o(m_err),
`endif
        .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_code_i(cfg_code),
        .cfg_plen_i(cfg_plen), .cfg_prefix_i(cfg_prefix),
        .cfg_cwlen_i(cfg_cwlen), .cfg_cw_i(cfg_cw)
    );
`ifndef LEC_MISS_FLAG_EN
    assign m_err = 1'b0;
`endif

    task automatic write_entry(input logic [5:0] addr, input logic [3:0] code,
                               input logic [5:0] plen, input logic [63:0] prefix,
                               input logic [5:0] cwlen, input logic [20:0] cw);
        cfg_we = 1'b1; cfg_addr = addr; cfg_code = code; cfg_plen = plen;
        cfg_prefix = prefix; cfg_cwlen = cwlen; cfg_cw = cw;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic send_sym(input logic [3:0] sym, input logic fl, input logic [3:0] code);
        int n = 0;
        while (!s_ready && n < 20) begin @(negedge clk); n++; end
        total++;
        if (s_ready !== 1'b1) $display("FAIL send_ready: s_ready=%b required 1", s_ready);
        else passed++;
        s_valid = 1'b1; s_sym = sym; s_flush = fl; s_code = code;
        @(negedge clk);
        s_valid = 1'b0; s_flush = 1'b0;
    endtask

    task automatic wait_beat(input string name, input logic [20:0] data,
                             input logic [5:0] len, input logic [3:0] code, input logic err);
        int n = 0;
        while (!m_valid && n < 20) begin @(negedge clk); n++; end
        total++;
        if (m_valid !== 1'b1) $display("FAIL %s_valid: m_valid=%b required 1", name, m_valid);
        else passed++;
        total++;
        if (m_data !== data) $display("FAIL %s_data: got %h required %h", name, m_data, data);
        else passed++;
        total++;
        if (m_len !== len) $display("FAIL %s_len: got %0d required %0d", name, m_len, len);
        else passed++;
        total++;
        if (m_code !== code) $display("FAIL %s_code: got %0d required %0d", name, m_code, code);
        else passed++;
`ifdef LEC_MISS_FLAG_EN
        total++;
        if (m_err !== err) $display("FAIL %s_err: got %b required %b", name, m_err, err);
        else passed++;
`endif
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic no_beat(input string name, input int cycles);
        logic seen = 1'b0;
        repeat (cycles) begin @(negedge clk); if (m_valid !== 1'b0) seen = 1'b1; end
        total++;
        if (seen) $display("FAIL %s_nobeat: m_valid seen 1 required 0", name);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({s_ready, m_valid, m_data, m_len, m_code, m_err} !== '0)
            $display("FAIL reset_outputs: rdy=%b vld=%b data=%h len=%0d code=%0d err=%b required all 0",
                     s_ready, m_valid, m_data, m_len, m_code, m_err);
        else passed++;
        rst = 1'b0;
        total++;
        if (s_ready !== 1'b0) $display("FAIL reset_idle: s_ready=%b required 0", s_ready);
        else passed++;
        @(negedge clk);
        total++;
        if (s_ready !== 1'b1) $display("FAIL reset_accum: s_ready=%b required 1", s_ready);
        else passed++;
    endtask

    task automatic test_flush_empty();
        write_entry(6'd0, 4'd2, 6'd1, 64'hF, 6'd6, 21'b101000);
        send_sym(4'h0, 1'b1, 4'd2);
        total++;
        if (m_valid !== 1'b0 || s_ready !== 1'b0)
            $display("FAIL lat_lookup: vld=%b rdy=%b required 0 0", m_valid, s_ready);
        else passed++;
        @(negedge clk);
        total++;
        if (m_valid !== 1'b1) $display("FAIL lat_emit: m_valid=%b required 1", m_valid);
        else passed++;
        wait_beat("flush_empty", 21'h28, 6'd6, 4'd2, 1'b0);
        total++;
        if (s_ready !== 1'b1) $display("FAIL post_emit_ready: s_ready=%b required 1", s_ready);
        else passed++;
    endtask

    task automatic test_two_sym();
        write_entry(6'd1, 4'd2, 6'd2, 64'h1F, 6'd9, 21'b111011111);
        send_sym(4'h1, 1'b0, 4'd2);
        no_beat("sym1_only", 5);
        send_sym(4'h0, 1'b1, 4'd2);
        wait_beat("two_sym", 21'h1DF, 6'd9, 4'd2, 1'b0);
    endtask

    task automatic test_backpressure();
        write_entry(6'd2, 4'd2, 6'd3, 64'h23F, 6'd12, 21'b111111111100);
        send_sym(4'h2, 1'b0, 4'd2);
        send_sym(4'h3, 1'b0, 4'd2);
        send_sym(4'h0, 1'b1, 4'd2);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            total++;
            if (m_valid !== 1'b1 || m_data !== 21'hFFC || m_len !== 6'd12 || s_ready !== 1'b0)
                $display("FAIL hold_c%0d: vld=%b data=%h len=%0d rdy=%b required 1 ffc 12 0",
                         c, m_valid, m_data, m_len, s_ready);
            else passed++;
            @(negedge clk);
        end
        wait_beat("backpressure", 21'hFFC, 6'd12, 4'd2, 1'b0);
        no_beat("bp_single", 6);
    endtask

    task automatic test_priority();
        write_entry(6'd1, 4'd2, 6'd0, 64'h0, 6'd0, 21'h0);
        write_entry(6'd5, 4'd2, 6'd2, 64'h1F, 6'd9, 21'h155);
        write_entry(6'd3, 4'd2, 6'd2, 64'h1F, 6'd9, 21'h0AA);
        send_sym(4'h1, 1'b0, 4'd2);
        send_sym(4'h0, 1'b1, 4'd2);
        wait_beat("priority", 21'h0AA, 6'd9, 4'd2, 1'b0);
    endtask

    task automatic test_miss();
        for (int i = 0; i < 16; i++) send_sym(4'h7, 1'b0, 4'd2);
`ifdef LEC_MISS_FLAG_EN
        wait_beat("miss16", 21'h0, 6'd0, 4'd2, 1'b1);
`else
        no_beat("miss16", 6);
        total++;
        if (s_ready !== 1'b1) $display("FAIL miss16_ready: s_ready=%b required 1", s_ready);
        else passed++;
`endif
        send_sym(4'h0, 1'b1, 4'd5);
`ifdef LEC_MISS_FLAG_EN
        wait_beat("code_miss", 21'h0, 6'd0, 4'd5, 1'b1);
`else
        no_beat("code_miss", 6);
`endif
        send_sym(4'hF, 1'b0, 4'd2);
        wait_beat("after_miss", 21'h28, 6'd6, 4'd2, 1'b0);
    endtask

    task automatic test_reset_emit();
        int n = 0;
        send_sym(4'h0, 1'b1, 4'd2);
        while (!m_valid && n < 20) begin @(negedge clk); n++; end
        total++;
        if (m_valid !== 1'b1) $display("FAIL rst_emit_pre: m_valid=%b required 1", m_valid);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if (m_valid !== 1'b0 || m_data !== 21'h0)
            $display("FAIL rst_emit_drop: vld=%b data=%h required 0 0", m_valid, m_data);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        send_sym(4'h0, 1'b1, 4'd2);
        no_beat("rst_table_empty", 8);
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_sym = '0; s_flush = 1'b0; s_code = '0;
        m_ready = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_code = '0;
        cfg_plen = '0; cfg_prefix = '0; cfg_cwlen = '0; cfg_cw = '0;
        @(negedge clk);
        test_reset();
        test_flush_empty();
        test_two_sym();
        test_backpressure();
        test_priority();
        test_miss();
        test_reset_emit();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
